// File: rtl/latch_write_sequencer.sv
// Writer side of a gated-D-latch bank: turns valid/ready write requests into
// setup / enable-pulse / hold sequences on a shared data bus with one-hot enables.
module latch_write_sequencer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 3,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [ADDR_W-1:0] IN_ADDR,
    input  logic [WIDTH-1:0]  IN_DATA,
    output logic [WIDTH-1:0]  LD,
    output logic [DEPTH-1:0]  LE,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [ADDR_W-1:0]  addr_q, addr_n;
    logic [WIDTH-1:0]   ld_n;
    logic [DEPTH-1:0]   le_n, sel;
    logic               busy_n, done_n, err_n, ready_n;
    logic               clr_pend;

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            sel[i] = (addr_q == ADDR_W'(i));
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = addr_q;
        ld_n    = LD;
        le_n    = '0;
        busy_n  = 1'b1;
        done_n  = 1'b0;
        err_n   = 1'b0;
        ready_n = 1'b0;
        case (state)
            IDLE: begin
                busy_n  = 1'b0;
                ready_n = 1'b1;
                if (IN_VALID && IN_READY) begin
                    if ({1'b0, IN_ADDR} < DEPTH_L) begin
                        state_n = SETUP;
                        cnt_n   = '0;
                        addr_n  = IN_ADDR;
                        ld_n    = IN_DATA;
                        busy_n  = 1'b1;
                        ready_n = 1'b0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_n = PULSE;
                    cnt_n   = '0;
                    le_n    = sel;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PULSE: begin
                if (cnt == PULSE_LAST) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end else begin
                    le_n  = sel;
                    cnt_n = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    ready_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Reset during an enable pulse keeps LD one more cycle so the latch sees hold time.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            LE       <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            IN_READY <= 1'b0;
            clr_pend <= |LE;
            LD       <= (|LE) ? LD : '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            addr_q   <= addr_n;
            LE       <= le_n;
            BUSY     <= busy_n;
            DONE     <= done_n;
            ERR      <= err_n;
            IN_READY <= ready_n;
            clr_pend <= 1'b0;
            LD       <= clr_pend ? '0 : ld_n;
        end
    end

endmodule
